rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter with grant hold and a hold-time limit. It sequences access to a shared 4-way resource. It produces a registered one-hot grant, plus the equivalent binary index and enable pair that drive the downstream 2-to-4 decoder (select + enable). Every grant is separated from the next by exactly one idle cycle.

---
 rtl/rr_arbiter_4_if.sv | 26 ++
 rtl/rr_arbiter_4.sv | 111 +++++++++++
 tb/tb_rr_arbiter_4.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if: handshake bundle between the requesters and the arbiter.
//   req     [0:3]  request vector, req[i] belongs to requester i
//   done    [0:3]  release pulse, only the owner's bit is honoured
//   gnt     [0:3]  registered one-hot grant
//   gnt_idx [1:0]  binary index of the owner (0 when idle)
//   gnt_en         grant active, equals |gnt
//   timeout        one-cycle pulse on a hold-limit release
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
  logic [0:3] req;
  logic [0:3] done;
  logic [0:3] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_en;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_en, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_en, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with grant hold and a
// hold-time limit. Grants are separated by exactly one idle (GAP) cycle.
//   MAX_HOLD  maximum consecutive grant cycles for one owner (2..255)
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       rr_arbiter_4_if slave modport (req/done in, grant outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant, arbitrate every cycle
// S_GRANT | owner idx_q holds the grant, hold_q counts its cycles
// S_GAP   | one mandatory zero cycle after a release, then arbitrate
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_arbiter_4_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [7:0] hold_q;
  logic [0:3] gnt_q;
  logic [1:0] idx_q;
  logic       en_q;
  logic       timeout_q;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_lim;

  function automatic logic [0:3] onehot(input logic [1:0] i);
    logic [0:3] v;
    v    = 4'b0000;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan from the farthest offset down to ptr so the nearest pending
  // requester (in round-robin order) is the last one to overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign rel_done = bus.done[idx_q];
  assign rel_drop = !bus.req[idx_q];
  assign rel_lim  = (hold_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 4'b0000;
      idx_q     <= 2'd0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_GRANT: begin
          if (rel_done || rel_drop || rel_lim) begin
            state_q   <= S_GAP;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            en_q      <= 1'b0;
            hold_q    <= 8'd0;
            ptr_q     <= idx_q + 2'd1;
            // Only a pure hold-limit release is reported as a timeout.
            timeout_q <= rel_lim && !rel_done && !rel_drop;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          // S_IDLE and S_GAP share arbitration; GAP falls back to IDLE.
          timeout_q <= 1'b0;
          if (win_vld) begin
            state_q <= S_GRANT;
            gnt_q   <= onehot(win_idx);
            idx_q   <= win_idx;
            en_q    <= 1'b1;
            hold_q  <= 8'd0;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_en  = en_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who owns the resource, how long it has held it,
  // where the round-robin search starts, and whether a gap is owed.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_ptr   = 0;
  bit   m_gap   = 0;
  bit   m_to    = 0;

  int   seq_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [0:3] r, input int p);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  task automatic model_step(input logic [0:3] r, input logic [0:3] d, input bit rs);
    bit rel;
    if (rs) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_gap = 0; m_to = 0;
    end else if (m_owner >= 0) begin
      rel = d[m_owner] || !r[m_owner] || (m_held == MH);
      if (rel) begin
        m_to    = (m_held == MH) && !d[m_owner] && r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else begin
      m_gap   = 0;
      m_to    = 0;
      m_owner = pick(r, m_ptr);
      m_held  = (m_owner >= 0) ? 1 : 0;
      if (m_owner >= 0) seq_q.push_back(m_owner);
    end
  endtask

  task automatic cycle(input logic [0:3] r, input logic [0:3] d, input bit rs);
    logic [0:3] e;
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
    e = 4'b0000;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    check("gnt",     32'(bus.gnt),     32'(e));
    check("gnt_idx", 32'(bus.gnt_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("gnt_en",  32'(bus.gnt_en),  (m_owner >= 0) ? 32'd1 : 32'd0);
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  function automatic logic [0:3] bit_of(input int i);
    logic [0:3] v;
    v = 4'b0000;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    bus.req  = 4'b0000;
    bus.done = 4'b0000;

    // Reset with everything asserted, then first grant to requester 0.
    cycle(4'b1111, 4'b1111, 1'b1);
    cycle(4'b1111, 4'b1111, 1'b1);
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    cycle(4'b1111, 4'b0000, 1'b0);
    check("first_gnt", 32'(bus.gnt), 32'(4'b1000));
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Single requester, done on its 3rd grant cycle.
    repeat (3) cycle(4'b0100, 4'b0000, 1'b0);
    check("single_idx", 32'(bus.gnt_idx), 32'd1);
    cycle(4'b0100, 4'b0100, 1'b0);
    check("single_gap", 32'(bus.gnt), 32'h0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Round robin from a clean reset: each owner leaves on its 2nd cycle.
    cycle(4'b0000, 4'b0000, 1'b1);
    seq_q.delete();
    for (int c = 0; c < 14; c++)
      cycle(4'b1111, (m_owner >= 0 && m_held == 2) ? bit_of(m_owner) : 4'b0000, 1'b0);
    check("rr_len", 32'(seq_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq_q.size(); i++)
      check("rr_seq", 32'(seq_q[i]), 32'(i % 4));
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Hold limit with no done: 4 grant cycles, then a timeout gap.
    repeat (MH + 1) cycle(4'b0010, 4'b0000, 1'b0);
    check("limit_to", 32'(bus.timeout), 32'd1);
    cycle(4'b0010, 4'b0000, 1'b0);
    check("limit_regrant", 32'(bus.gnt), 32'(4'b0010));
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Hold limit coinciding with done: no timeout.
    for (int c = 0; c < MH + 1; c++)
      cycle(4'b0010, (m_held == MH) ? 4'b0010 : 4'b0000, 1'b0);
    check("limit_done_to", 32'(bus.timeout), 32'd0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Non-owner done/req are ignored; owner 0 then drops.
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b1001, 4'b0000, 1'b0);
    repeat (2) cycle(4'b1001, 4'b0111, 1'b0);
    check("nonowner_hold", 32'(bus.gnt), 32'(4'b1000));
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    check("nonowner_next", 32'(bus.gnt), 32'(4'b0001));
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // Reset while requester 2 owns the grant.
    cycle(4'b0000, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b1111, 4'b0000, 1'b1);
    check("midrst_gnt", 32'(bus.gnt), 32'h0);
    cycle(4'b1111, 4'b0000, 1'b0);
    check("midrst_next", 32'(bus.gnt), 32'(4'b1000));

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      logic [0:3] r, d;
      r = 4'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 1) == 0 && m_owner >= 0) r[m_owner] = 1'b1;
      cycle(r, d, ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
